// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - shared FSM encodings, in_buffer state codes and default layer table
package conv_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_NEXT    = 3'd3,
    S_DONE    = 3'd4
  } seq_state_e;

  // in_buffer i_state codes
  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_IMAGES_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND_DATA   = 2'd2;

  localparam int DEF_NUM_LAYERS = 3;
  localparam int DEF_ROWS       = 16;
  localparam int DEF_IC_LAST_L0 = 0;
  localparam int DEF_IC_LAST_LN = 63;
  localparam int DEF_OC_LAST    = 63;

  function automatic logic [1:0] state_code(input seq_state_e s);
    case (s)
      S_LOAD:    return ST_IMAGES_LOAD;
      S_COMPUTE: return ST_SEND_DATA;
      default:   return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/seq_loop_cnt.sv
// rtl/seq_loop_cnt.sv - nested layer/oc/ic loop counter with clear, advance and last-iteration flag
module seq_loop_cnt
  import conv_seq_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int IC_LAST_L0 = DEF_IC_LAST_L0,
  parameter int IC_LAST_LN = DEF_IC_LAST_LN,
  parameter int OC_LAST    = DEF_OC_LAST
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       advance,
  output logic [1:0] layer,
  output logic [5:0] ic,
  output logic [5:0] oc,
  output logic       last
);

  logic [5:0] ic_last;

  // layer 0 sees the raw image, so it has its own input-channel depth
  assign ic_last = (layer == 2'd0) ? 6'(IC_LAST_L0) : 6'(IC_LAST_LN);
  assign last    = (ic == ic_last) && (oc == 6'(OC_LAST)) && (layer == 2'(NUM_LAYERS - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      layer <= 2'd0;
      ic    <= 6'd0;
      oc    <= 6'd0;
    end else if (advance) begin
      if (ic != ic_last) begin
        ic <= ic + 6'd1;
      end else begin
        ic <= 6'd0;
        if (oc != 6'(OC_LAST)) begin
          oc <= oc + 6'd1;
        end else begin
          oc <= 6'd0;
          if (layer != 2'(NUM_LAYERS - 1)) layer <= layer + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// rtl/conv_layer_sequencer.sv - layer/oc/ic loop sequencer driving in_buffer load and compute passes
// Optional SEQ_PERF_CNT_EN adds saturating load/compute cycle counters.
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int ROWS       = DEF_ROWS,
  parameter int IC_LAST_L0 = DEF_IC_LAST_L0,
  parameter int IC_LAST_LN = DEF_IC_LAST_LN,
  parameter int OC_LAST    = DEF_OC_LAST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_load_done,
  input  logic        i_row_done,
  input  logic        i_send_flg,
  output logic [1:0]  o_state,
  output logic [1:0]  o_current_layer,
  output logic [5:0]  o_current_ic,
  output logic [5:0]  o_current_oc,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] o_load_cycles,
  output logic [31:0] o_comp_cycles
`endif
);

  localparam int RC_W = $clog2(ROWS + 1);

  seq_state_e      state;
  seq_state_e      state_next;
  logic [RC_W-1:0] row_cnt;
  logic            accept_start;
  logic            do_abort;
  logic            cnt_clear;
  logic            cnt_advance;
  logic            pass_bad;
  logic            loop_last;

  seq_loop_cnt #(
    .NUM_LAYERS (NUM_LAYERS),
    .IC_LAST_L0 (IC_LAST_L0),
    .IC_LAST_LN (IC_LAST_LN),
    .OC_LAST    (OC_LAST)
  ) u_loop_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .layer   (o_current_layer),
    .ic      (o_current_ic),
    .oc      (o_current_oc),
    .last    (loop_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    accept_start = 1'b0;
    cnt_advance  = 1'b0;
    pass_bad     = 1'b0;
    do_abort     = i_abort && (state != S_IDLE);
    if (do_abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            state_next   = S_LOAD;
            accept_start = 1'b1;
          end
        end
        S_LOAD: begin
          if (i_load_done) state_next = S_COMPUTE;
        end
        S_COMPUTE: begin
          if (i_send_flg) begin
            state_next = S_NEXT;
            // the final row_done may coincide with send_flg
            pass_bad   = !((row_cnt == RC_W'(ROWS)) ||
                           ((row_cnt == RC_W'(ROWS - 1)) && i_row_done));
          end
        end
        S_NEXT: begin
          cnt_advance = 1'b1;
          state_next  = loop_last ? S_DONE : S_LOAD;
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
    cnt_clear = accept_start || do_abort;
  end

  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      o_state <= ST_IDLE;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
      row_cnt <= '0;
    end else begin
      o_state <= state_code(state_next);
      o_valid <= (state_next == S_COMPUTE);
      o_busy  <= (state_next == S_LOAD) || (state_next == S_COMPUTE) || (state_next == S_NEXT);
      o_done  <= (state_next == S_DONE);
      if (accept_start)  o_err <= 1'b0;
      else if (pass_bad) o_err <= 1'b1;
      if (cnt_clear || state == S_NEXT) begin
        row_cnt <= '0;
      end else if (state == S_COMPUTE && i_row_done && row_cnt != RC_W'(ROWS)) begin
        row_cnt <= row_cnt + 1'b1;
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || accept_start) begin
      o_load_cycles <= '0;
      o_comp_cycles <= '0;
    end else begin
      if (state == S_LOAD && o_load_cycles != '1)    o_load_cycles <= o_load_cycles + 32'd1;
      if (state == S_COMPUTE && o_comp_cycles != '1) o_comp_cycles <= o_comp_cycles + 32'd1;
    end
  end
`endif

endmodule
